mult8_seq_ctrl: RTL and testbench
=================================

Name: mult8_seq_ctrl

Overview:
- Iterative shift-and-add multiplier controller for unsigned WIDTH x WIDTH products.
- One shared mux+adder step is reused over WIDTH cycles instead of WIDTH-1 unrolled adder stages.
- Sits wherever a low-area multiplier is needed in a garbling/synthesis flow.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH), step counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  multiplier operand (bits scanned LSB first).
- in_b  input  WIDTH  multiplicand operand.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_o  output  2*WIDTH  product in_a*in_b; holds its value while out_valid is high.
- busy  output  1  high in RUN state.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_o=0, acc=0, cnt=0, a_reg=0, b_reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: a_reg<=in_a, b_reg<=zero-extend(in_b) to 2*WIDTH, acc<=0, cnt<=0; go RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: acc<=acc + (a_reg[cnt] ? (b_reg<<cnt) : 0), truncated to 2*WIDTH bits (never overflows for unsigned operands).
  - cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: go DONE, out_o<=final acc.
- Latency: out_valid rises after edge k+WIDTH, i.e. WIDTH cycles after the accept edge (8 for the default).
- DONE:
  - out_valid=1, in_ready=0.
  - out_o is stable until out_valid&&out_ready; that edge returns to IDLE and clears out_valid.
  - out_ready low holds DONE indefinitely; no result is dropped.
- No overlap: a new operand pair is accepted only in IDLE, earliest the cycle after the output handshake. Throughput is one product per WIDTH+2 cycles.
- in_valid in RUN or DONE is ignored; the requester must hold it, since in_ready=0.
- Operand inputs are sampled only at the accept edge; later changes have no effect on the running product.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the partial product is discarded and nothing is emitted.
- Step counter wrap: cnt never exceeds WIDTH-1; it is cleared on accept.

Optional Feature:
- Macro MULT_SEQ_EARLY_EXIT_EN.
- Defined:
  - a_reg shifts right each RUN step, and bit 0 is used instead of a_reg[cnt].
  - If the shifted remainder is zero after a step, go DONE immediately.
  - Latency = (index of highest set bit of in_a)+1; in_a=0 gives latency 1 with product 0.
- Undefined: fixed WIDTH-cycle latency as above.
- Product values are identical in both builds.

Decomposition:
- Shared package mult_seq_pkg: state enum (IDLE/RUN/DONE), step-count constant derivation, product-width localparam helper.
- One sub-module, mult_step: combinational gated-shifted-add (select shifted multiplicand or zero, add to accumulator, 2*WIDTH wide). It is built from the existing 16-bit mux and adder cells for WIDTH=8.
- The FSM and registers stay in mult8_seq_ctrl.

Test Plan:
- Basic product: A=8'd13, B=8'd11 accepted, out_ready=1 -> out_valid exactly 8 cycles after accept, out_o=16'd143, then in_ready=1 next cycle.
- Extremes: A=B=8'hFF -> out_o=16'hFE01. A=0,B=8'hFF -> 16'h0000. A=8'hFF,B=0 -> 16'h0000.
- Backpressure: A=3,B=5, out_ready low 20 cycles -> out_valid stays 1, out_o=16'd15 stable, in_ready=0 throughout; single transfer when out_ready rises.
- Mid-op reset: accept A=200,B=100, pulse rst_n low at step 4 -> all outputs at reset values asynchronously. Next A=2,B=2 -> out_o=4 with normal latency.
- Back-to-back plus input ignore: hold in_valid with changing in_a/in_b during RUN -> second pair accepted only after the output handshake. Random 1000 pairs match the A*B reference model.
- Early exit build: A=8'h01 -> latency 1. A=8'h80 -> latency 8. A=0 -> latency 1, product 0.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
// Used by mult8_seq_ctrl and mult_step.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter needs at least one bit even for a 1-bit multiplier.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-and-add step: add (mcand << shamt) to acc when sel is set,
// otherwise pass acc through. Purely combinational, PW bits wide.
module mult_step #(
    parameter int PW   = 16,
    parameter int SH_W = 3
) (
    input  logic [PW-1:0]   acc,
    input  logic [PW-1:0]   mcand,
    input  logic            sel,
    input  logic [SH_W-1:0] shamt,
    output logic [PW-1:0]   sum
);

    logic [PW-1:0] addend;

    assign addend = sel ? (mcand << shamt) : '0;
    assign sum    = acc + addend;

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Iterative unsigned WIDTH x WIDTH multiplier with valid/ready on both sides.
// Define MULT_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mult8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_o,
    output logic                 busy
);

    localparam int PW = prod_width(WIDTH);

    state_t           state_q, state_d;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    b_reg;
    logic [WIDTH-1:0] a_reg;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    step_sum;
    logic             step_bit;
    logic             last_step;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    // a_reg is consumed LSB first; once the unscanned bits are all zero the product is final.
    assign step_bit  = a_reg[0];
    assign last_step = (cnt == CNT_W'(WIDTH - 1)) || ((a_reg >> 1) == '0);
`else
    assign step_bit  = a_reg[cnt];
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

    mult_step #(
        .PW   (PW),
        .SH_W (CNT_W)
    ) u_step (
        .acc   (acc),
        .mcand (b_reg),
        .sel   (step_bit),
        .shamt (cnt),
        .sum   (step_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            b_reg <= '0;
            a_reg <= '0;
            cnt   <= '0;
            out_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= PW'(in_b);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= step_sum;
                    cnt <= last_step ? '0 : cnt + CNT_W'(1);
`ifdef MULT_SEQ_EARLY_EXIT_EN
                    a_reg <= a_reg >> 1;
`endif
                    if (last_step) out_o <= step_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl: the driver queues expected products,
// a negedge monitor checks latency and product on every output handshake.
module tb_mult8_seq_ctrl;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_o;
    logic        busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic prev_vld = 1'b0;

    mult8_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_o     (out_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 8; i++) if (a[i]) l = i + 1;
        return l;
`else
        return 8;
`endif
    endfunction

    // Monitor: latency on the rising edge of out_valid, product on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid && !prev_vld) begin
                if (sb.size() == 0) check("spurious_valid", 1, 0);
                else check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("product %0d*%0d", e.a, e.b), out_o, e.prod);
                end
            end
            prev_vld = out_valid;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] prod, input bit hold);
        exp_t e;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.a = a; e.b = b; e.prod = prod; e.lat = exp_lat(a); e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
        send(a, b, prod, 1'b0);
        wait_out();
        @(negedge clk);
    endtask

    initial begin
        #2;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst out_o", out_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic product, then idle again the cycle after the handshake
        send(8'd13, 8'd11, 16'd143, 1'b0);
        check("busy in run", busy, 1);
        check("in_ready in run", in_ready, 0);
        wait_out();
        @(negedge clk);
        check("in_ready after hs", in_ready, 1);
        check("out_valid after hs", out_valid, 0);

        // Extremes
        run_one(8'hFF, 8'hFF, 16'hFE01);
        run_one(8'h00, 8'hFF, 16'h0000);
        run_one(8'hFF, 8'h00, 16'h0000);

        // Backpressure
        @(posedge clk); #2 out_ready = 1'b0;
        @(negedge clk);
        send(8'd3, 8'd5, 16'd15, 1'b0);
        wait_out();
        for (int i = 0; i < 20; i++) begin
            check("bp out_valid", out_valid, 1);
            check("bp out_o", out_o, 16'd15);
            check("bp in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #2 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp single transfer", out_valid, 0);

        // Mid-op reset, partial product discarded
        send(8'd200, 8'd100, 16'd20000, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst out_o", out_o, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_one(8'd2, 8'd2, 16'd4);

        // Held in_valid with changing operands during RUN/DONE
        send(8'd7, 8'd9, 16'd63, 1'b1);
        for (int i = 0; i < 40 && !in_ready; i++) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
        end
        send(8'd6, 8'd4, 16'd24, 1'b0);
        wait_out();
        @(negedge clk);

        // Vectors that exercise the early-exit latency path
        run_one(8'h01, 8'd5, 16'd5);
        run_one(8'h80, 8'd3, 16'd384);
        run_one(8'h00, 8'd77, 16'd0);
        run_one(8'h10, 8'hF0, 16'h0F00);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            run_one(a, b, 16'(a) * 16'(b));
        end

        repeat (3) @(negedge clk);
        check("scoreboard empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
